// File: rtl/ysyx_210184_bus_arb_pkg.sv
// ysyx_210184_bus_arb_pkg: shared FSM state and bus-owner encodings, plus the default starvation limit for the bus arbiter.
package ysyx_210184_bus_arb_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;
  localparam int STARVE_MAX_DEF = 4;
endpackage

// File: rtl/ysyx_210184_bus_arb.sv
// ysyx_210184_bus_arb: data-priority fetch/data bus arbiter with fetch starvation guard; ports if_* fetch side, d_* data side, bus_* shared bus.
module ysyx_210184_bus_arb
  import ysyx_210184_bus_arb_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  input  logic                if_kill_i,
  output logic [31:0]         if_rdata_o,
  output logic                if_done_o,
  output logic                if_stall_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  input  logic [DATA_W/8-1:0] d_wstrb_i,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                d_done_o,
  output logic                d_stall_o,
  output logic                bus_valid_o,
  input  logic                bus_ready_i,
  output logic                bus_we_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [DATA_W-1:0]   bus_wdata_o,
  output logic [DATA_W/8-1:0] bus_wstrb_o,
  input  logic                bus_rvalid_i,
  input  logic [DATA_W-1:0]   bus_rdata_i
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);
  state_t state, state_n;
  owner_t owner;
  logic drop;
  logic [CW-1:0] starve_cnt;
  logic [DATA_W-1:0] rdata;
  logic f_cand, grant, grant_d;
  assign f_cand  = if_req_i & ~if_kill_i;
  assign grant   = f_cand | d_req_i;
  assign grant_d = d_req_i & ~(f_cand & (starve_cnt == SMAX));
  assign if_rdata_o = bus_addr_o[2] ? rdata[63:32] : rdata[31:0];
  assign d_rdata_o  = rdata;
  always_comb begin
    state_n = state == S_IDLE ? (grant ? S_ADDR : S_IDLE)
            : state == S_ADDR ? (bus_ready_i ? S_RESP : S_ADDR)
            : state == S_RESP ? (bus_rvalid_i ? S_DONE : S_RESP)
            : S_IDLE;
    d_done_o   = state == S_DONE && owner == OWN_D;
    if_done_o  = state == S_DONE && owner == OWN_IF && !drop && !if_kill_i;
    if_stall_o = if_req_i & ~if_done_o & ~if_kill_i;
    d_stall_o  = d_req_i & ~d_done_o;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      owner       <= OWN_IF;
      drop        <= 1'b0;
      starve_cnt  <= '0;
      rdata       <= '0;
      bus_valid_o <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      bus_wstrb_o <= '0;
    end else begin
      state       <= state_n;
      bus_valid_o <= state_n == S_ADDR;
      if (state == S_IDLE && grant) begin
        owner       <= grant_d ? OWN_D : OWN_IF;
        bus_we_o    <= grant_d & d_we_i;
        bus_addr_o  <= grant_d ? d_addr_i : if_addr_i;
        bus_wdata_o <= grant_d ? d_wdata_i : '0;
        bus_wstrb_o <= grant_d ? d_wstrb_i : '0;
        drop        <= 1'b0;
        starve_cnt  <= !grant_d ? '0
                     : (f_cand && starve_cnt != SMAX) ? starve_cnt + 1'b1
                     : starve_cnt;
      end
      // a killed fetch still finishes its bus handshake; only its done pulse is dropped
      if ((state == S_ADDR || state == S_RESP) && owner == OWN_IF && if_kill_i) drop <= 1'b1;
      if (state == S_RESP && bus_rvalid_i) rdata <= bus_rdata_i;
    end
  end
endmodule

// File: tb/tb_ysyx_210184_bus_arb.sv
// tb_ysyx_210184_bus_arb: randomized scoreboard bench for the fetch/data bus arbiter.
module tb_ysyx_210184_bus_arb;
  import ysyx_210184_bus_arb_pkg::*;
  localparam int N = 6000;
  logic clk = 1'b0;
  logic rst;
  logic if_req_i, if_kill_i, if_done_o, if_stall_o;
  logic [63:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic d_req_i, d_we_i, d_done_o, d_stall_o;
  logic [63:0] d_addr_i, d_wdata_i, d_rdata_o;
  logic [7:0] d_wstrb_i;
  logic bus_valid_o, bus_ready_i, bus_we_o, bus_rvalid_i;
  logic [63:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic [7:0] bus_wstrb_o;
  always #5 clk = ~clk;
  ysyx_210184_bus_arb dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_kill_i(if_kill_i),
    .if_rdata_o(if_rdata_o), .if_done_o(if_done_o), .if_stall_o(if_stall_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_wstrb_i(d_wstrb_i), .d_rdata_o(d_rdata_o), .d_done_o(d_done_o), .d_stall_o(d_stall_o),
    .bus_valid_o(bus_valid_o), .bus_ready_i(bus_ready_i), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_wstrb_o(bus_wstrb_o),
    .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
  );
  typedef struct packed {
    bit rst, if_req, kill, d_req, we, ready, rvalid;
    logic [63:0] if_addr, d_addr, wdata, rdata;
    logic [7:0] wstrb;
  } drv_t;
  typedef struct packed {
    int cyc;
    logic [63:0] data;
  } exp_t;
  drv_t cur, prv;
  exp_t if_q[$], d_q[$];
  int cyc, errors, checks;
  bit ei, ed;
  logic s_valid, s_we;
  logic [63:0] s_addr, s_wdata;
  logic [7:0] s_wstrb;
  bit t_act, t_d, t_acc, t_rsp, t_kill, t_we, fc, dc, mid_rst;
  int t_acc_cyc, starve, if_done_at, d_done_at, drate;
  logic [63:0] t_addr, t_wdata;
  logic [7:0] t_wstrb;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask
  task automatic apply();
    rst          = cur.rst;
    if_req_i     = cur.if_req;
    if_addr_i    = cur.if_addr;
    if_kill_i    = cur.kill;
    d_req_i      = cur.d_req;
    d_we_i       = cur.we;
    d_addr_i     = cur.d_addr;
    d_wdata_i    = cur.wdata;
    d_wstrb_i    = cur.wstrb;
    bus_ready_i  = cur.ready;
    bus_rvalid_i = cur.rvalid;
    bus_rdata_i  = cur.rdata;
  endtask
  initial forever begin
    @(negedge clk);
    if (cyc >= 1) begin
      s_valid = bus_valid_o;
      s_we    = bus_we_o;
      s_addr  = bus_addr_o;
      s_wdata = bus_wdata_o;
      s_wstrb = bus_wstrb_o;
      ei = if_q.size() > 0 && if_q[0].cyc == cyc;
      ed = d_q.size() > 0 && d_q[0].cyc == cyc;
      chk("if_done", if_done_o, ei);
      chk("d_done", d_done_o, ed);
      if (ei && if_done_o) chk("if_rdata", if_rdata_o, if_q[0].data);
      if (ed && d_done_o) chk("d_rdata", d_rdata_o, d_q[0].data);
      if (ei) void'(if_q.pop_front());
      if (ed) void'(d_q.pop_front());
      chk("if_stall", if_stall_o, cur.if_req & ~ei & ~cur.kill);
      chk("d_stall", d_stall_o, cur.d_req & ~ed);
      if (prv.rst) begin
        chk("rst_valid", bus_valid_o, 0);
        chk("rst_addr", bus_addr_o, 0);
        chk("rst_we", bus_we_o, 0);
        chk("rst_d_rdata", d_rdata_o, 0);
        chk("rst_if_rdata", if_rdata_o, 0);
      end
    end
  end
  initial begin
    cur = '0;
    cur.rst = 1'b1;
    prv = '0;
    if_done_at = -1;
    d_done_at = -1;
    apply();
    for (int k = 1; k <= N; k++) begin
      @(posedge clk);
      #1;
      cyc = k;
      prv = cur;
      drate = ((k / 500) % 2) != 0 ? 95 : 35;
      cur.rst = k < 3;
      cur.kill = 1'b0;
      if (prv.rst) begin
        cur.if_req = 1'b0;
        cur.d_req = 1'b0;
      end
      if (cur.if_req && (prv.kill || if_done_at == k - 1)) cur.if_req = 1'b0;
      if (cur.d_req && d_done_at == k - 1) cur.d_req = 1'b0;
      if (k < N - 150) begin
        if (!cur.if_req && $urandom_range(99) < 50) begin
          cur.if_req = 1'b1;
          cur.if_addr = {32'h0, 32'h8000_0000 | ($urandom & 32'hffc)};
        end
        if (!cur.d_req && $urandom_range(99) < drate) begin
          cur.d_req = 1'b1;
          cur.we = 1'($urandom);
          cur.d_addr = {32'h0, 32'h9000_0000 | ($urandom & 32'hff8)};
          cur.wdata = {$urandom, $urandom};
          cur.wstrb = 8'($urandom);
        end
      end
      if (cur.if_req && $urandom_range(99) < 6) cur.kill = 1'b1;
      if (prv.rst) begin
        t_act = 0;
        starve = 0;
        if_q.delete();
        d_q.delete();
        if_done_at = -1;
        d_done_at = -1;
      end else if (t_act) begin
        if (!t_d && prv.kill) t_kill = 1;
        if (!t_acc) begin
          chk("bus_valid", s_valid, 1);
          chk("bus_addr", s_addr, t_addr);
          chk("bus_we", s_we, t_we);
          chk("bus_wstrb", s_wstrb, t_wstrb);
          if (t_d) chk("bus_wdata", s_wdata, t_wdata);
          if (prv.ready) begin
            t_acc = 1;
            t_acc_cyc = k - 1;
          end
        end else begin
          chk("bus_valid_low", s_valid, 0);
          if (t_rsp) t_act = 0;
          else if (prv.rvalid && k - 1 > t_acc_cyc) begin
            t_rsp = 1;
            if (t_d) begin
              d_q.push_back('{k, prv.rdata});
              d_done_at = k;
            end else if (!(t_kill || cur.kill)) begin
              if_q.push_back('{k, t_addr[2] ? {32'h0, prv.rdata[63:32]} : {32'h0, prv.rdata[31:0]}});
              if_done_at = k;
            end
          end
        end
      end else begin
        chk("bus_valid_idle", s_valid, 0);
        fc = prv.if_req & ~prv.kill;
        dc = prv.d_req;
        if (fc | dc) begin
          t_d = dc && !(fc && starve == 4);
          if (!t_d) starve = 0;
          else if (fc) starve = starve < 4 ? starve + 1 : 4;
          t_act = 1;
          t_acc = 0;
          t_rsp = 0;
          t_kill = 0;
          t_addr = t_d ? prv.d_addr : prv.if_addr;
          t_we = t_d & prv.we;
          t_wdata = prv.wdata;
          t_wstrb = t_d ? prv.wstrb : 8'h0;
        end
      end
      cur.ready = $urandom_range(99) < 55;
      cur.rvalid = (t_act && t_acc && !t_rsp) ? $urandom_range(99) < 45 : $urandom_range(99) < 10;
      cur.rdata = {$urandom, $urandom};
      if (k > 3 && t_act && !t_acc && ((!mid_rst && k > N / 2) || $urandom_range(399) == 0)) begin
        cur.rst = 1'b1;
        mid_rst = 1;
      end
      apply();
    end
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ysyx_210184_bus_arb.md
# ysyx_210184_bus_arb

Two-requester arbiter that shares the core's single memory bus port between instruction fetch (IF) and data access (MEM load/store). It runs one outstanding transaction at a time and gives data priority, with a starvation guard for fetch. It returns read data and a one-cycle done pulse to the winner, and drives the stall levels the pipeline uses to freeze IF and MEM. It sits between the IF/MEM stages and the bus/AXI bridge.

## Interface
- `ADDR_W`, default 64: address width.
- `DATA_W`, default 64: bus data width.
- `STARVE_MAX`, default 4: consecutive data grants allowed while fetch waits.
- Clock and reset (already decided): clock `clk`; reset `rst`, synchronous, active-high.
- `clk`  in  1  clock.
- `rst`  in  1  reset.
- `if_req_i`  in  1  fetch request level; held until `if_done_o` or kill.
- `if_addr_i`  in  ADDR_W  fetch address; bits [1:0] are 0.
- `if_kill_i`  in  1  flush; discards a pending or in-flight fetch.
- `if_rdata_o`  out  32  fetched instruction.
- `if_done_o`  out  1  one-cycle fetch completion.
- `if_stall_o`  out  1  fetch waiting.
- `d_req_i`  in  1  data request level; held until `d_done_o`.
- `d_we_i`  in  1  1 = write.
- `d_addr_i`  in  ADDR_W  data address.
- `d_wdata_i`  in  DATA_W  write data.
- `d_wstrb_i`  in  DATA_W/8  byte strobes.
- `d_rdata_o`  out  DATA_W  load data.
- `d_done_o`  out  1  one-cycle data completion.
- `d_stall_o`  out  1  data waiting.
- `bus_valid_o`  out  1  request valid.
- `bus_ready_i`  in  1  request accepted.
- `bus_we_o`  out  1  write.
- `bus_addr_o`  out  ADDR_W  address.
- `bus_wdata_o`  out  DATA_W  write data.
- `bus_wstrb_o`  out  DATA_W/8  write strobes.
- `bus_rvalid_i`  in  1  response (read data, or write ack).
- `bus_rdata_i`  in  DATA_W  read data.

## Operation
- **FSM states:** IDLE, ADDR, RESP, DONE. Arbitration happens only in IDLE.
- **IDLE:** compute candidates.
  - Fetch is a candidate when `if_req_i & ~if_kill_i`. Data is a candidate when `d_req_i`.
  - Data wins, unless fetch is a candidate and `starve_cnt == STARVE_MAX`.
  - On a grant, latch owner, we, addr, wdata and wstrb (we/wstrb forced to 0 for fetch), clear `drop`, and go to ADDR.
- **ADDR:** `bus_valid_o = 1` with the latched fields.
  - Stay in ADDR until `bus_ready_i`, then go to RESP.
  - `bus_rvalid_i` is ignored in ADDR.
- **RESP:** on `bus_rvalid_i`, register `bus_rdata_i` and go to DONE.
- **DONE:** one cycle, then go to IDLE.
  - `d_done_o = (owner == D)`.
  - `if_done_o = (owner == IF) & ~drop & ~if_kill_i`.
- **Fetch data:** `if_rdata_o` is the latched rdata[63:32] if latched addr[2] = 1, else rdata[31:0].
- **Data output:** `d_rdata_o` is the full latched rdata.
- **Kill:** `if_kill_i` while the fetch owns ADDR or RESP sets `drop`.
  - The bus transaction still completes; `bus_valid_o` is never withdrawn before ready.
  - The done pulse for a dropped fetch is suppressed.
- **Starvation counter:** `starve_cnt` saturates at STARVE_MAX.
  - +1 when data is granted while fetch is a candidate.
  - Cleared when fetch is granted.
  - Unchanged otherwise.
- **Stalls:** `if_stall_o = if_req_i & ~if_done_o & ~if_kill_i`; `d_stall_o = d_req_i & ~d_done_o`.
- **Reset values:** state IDLE; owner, drop and starve_cnt = 0; all outputs 0; rdata = 0.
- **Reset mid-transaction:** the FSM returns to IDLE the next cycle and `bus_valid_o` drops. The bus bridge is reset by the same `rst`.

## Timing
- Minimum transaction is 4 cycles:
  - cycle 0: req seen in IDLE;
  - cycle 1: ADDR with ready;
  - cycle 2: RESP with rvalid;
  - cycle 3: DONE, done = 1;
  - cycle 4: IDLE, next arbitration.
- Each ready/rvalid wait cycle adds one cycle.
- A requester may present its next request in the DONE cycle or later. The arbiter samples it in IDLE, so there is no double grant on a stale request.
- Simultaneous requests in IDLE: the priority rule above resolves them in the same cycle.
- Kill arriving in the DONE cycle suppresses that cycle's `if_done_o`.
- All bus outputs are registered; the done outputs are decoded from state and registers.

## Structure
- **Shared package:** state encoding (IDLE = 0, ADDR = 1, RESP = 2, DONE = 3), owner encoding (IF = 0, D = 1), default STARVE_MAX.
- **Module:** a single flat module with no sub-module. The latch fields may use the shared `ysyx_210184_ff` register with stall tied to 0.

## Test plan
- **Single fetch:** `if_req_i = 1` at addr 0x8000_0004; bus ready in ADDR cycle 1, rvalid in RESP cycle 2 with rdata 0x1234_5678_0000_0013 -> DONE cycle 3, `if_done_o = 1`, `if_rdata_o = 0x1234_5678`.
- **Collision:** `if_req_i` and `d_req_i` (store to 0x8000_1000, wstrb 0xFF) both rise at t = 0 -> the store is granted and driven first with `bus_we_o = 1`. After its `d_done_o`, the fetch is granted and `if_stall_o` stays high throughout.
- **Starvation guard:** `d_req_i` held continuously with `if_req_i` also held -> 4 data grants, then the fetch is granted, then the counter clears.
- **Kill during RESP:** kill the fetch with rvalid delayed 3 cycles -> `bus_valid_o` handshake completes, `if_done_o` never pulses, the FSM reaches IDLE.
- **Ready backpressure:** `bus_ready_i = 0` for 5 cycles in ADDR -> `bus_valid_o` and addr are held stable for all 5 cycles.
- **Reset mid-ADDR:** `rst = 1` for 1 cycle -> next cycle `bus_valid_o = 0`, `starve_cnt = 0`, FSM in IDLE.
